uart_prog_loader: RTL and testbench

Parametrised UART program loader. It replaces the fixed-width UART programmer and the start-button / programming-reset glue in the CPU top. A debounced start_pg press puts the block into load mode and holds the CPU in reset. Received bytes are assembled little-endian into DATA_W-bit words and written sequentially into program/data memory. The block then reports a status byte (plus an optional checksum) on tx.

---
 rtl/uart_prog_loader_if.sv | 14 +
 rtl/uart_prog_loader.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_prog_loader_if.sv
// Memory-programming bus of the UART program loader.
// The loader drives it (master); program/data memory and the CPU top sample it (slave).
interface uart_prog_loader_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              upg_wen;
    logic [ADDR_W-1:0] upg_adr;
    logic [DATA_W-1:0] upg_dat;
    logic              upg_done;

    modport master (output upg_wen, upg_adr, upg_dat, upg_done);
    modport slave  (input  upg_wen, upg_adr, upg_dat, upg_done);
endinterface

// File: rtl/uart_prog_loader.sv
// UART program loader: a debounced start_pg press enters load mode and holds
// the CPU in reset. Received bytes are packed little-endian into DATA_W-bit
// words and written to sequential word addresses. A status byte ('O' or 'E')
// is then sent on tx.
// Optional feature macro: PROG_CKSUM_EN. When it is defined, a modulo-256 sum
// of all bytes of written words follows the status byte.
// The upg interface instance must use the same ADDR_W/DATA_W as this module.
module uart_prog_loader #(
    parameter int BAUD_DIV     = 781,
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int TIMEOUT_CYC  = 100000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_pg,
    input  logic               rx,
    output logic               tx,
    uart_prog_loader_if.master upg,
    output logic               prog_active,
    output logic               frame_err
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int BD_W  = $clog2(BAUD_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int TM_W  = $clog2(TIMEOUT_CYC + 1);
`ifdef PROG_CKSUM_EN
    localparam int TX_BITS = 20;
`else
    localparam int TX_BITS = 10;
`endif
    localparam int TXC_W = $clog2(TX_BITS);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NB - 1);
    localparam logic [BD_W-1:0]   BAUD_LAST = BD_W'(BAUD_DIV - 1);
    localparam logic [BD_W-1:0]   BAUD_HALF = BD_W'(BAUD_DIV / 2 - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TM_W-1:0]   TM_LAST   = TM_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] ADR_LAST  = '1;
    localparam logic [TXC_W-1:0]  TX_LAST   = TXC_W'(TX_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_REPORT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t             state_r;
    logic               rx_meta_r, rx_sync_r, rx_prev_r, pg_meta_r, pg_sync_r;
    logic [DB_W-1:0]    db_cnt_r;
    logic               db_armed_r, start_evt_r;
    logic               rx_busy_r;
    logic [BD_W-1:0]    rx_cnt_r;
    logic [3:0]         rx_bit_r;
    logic [7:0]         rx_shift_r;
    logic               rx_tick_s, rx_good_s, rx_bad_s;
    logic [IDX_W-1:0]   byte_idx_r;
    logic [DATA_W-1:0]  word_buf_r, word_next_s;
    logic [TM_W-1:0]    tmo_cnt_r;
    logic               got_byte_r;
    logic               full_s, tmo_s, to_report_s;
    logic [7:0]         status_s;
    logic [TX_BITS-1:0] tx_frame_s;
    logic [TX_BITS-2:0] tx_frame_r;
    logic [TXC_W-1:0]   tx_left_r;
    logic [BD_W-1:0]    tx_cnt_r;
    logic               tx_r;
    logic               upg_wen_r, upg_done_r, prog_active_r, frame_err_r;
    logic [ADDR_W-1:0]  upg_adr_r;
    logic [DATA_W-1:0]  upg_dat_r;
`ifdef PROG_CKSUM_EN
    logic [7:0]         sum_r, word_sum_r;
`endif

    // Two-flop synchronisers for rx and the button, plus previous rx for edge detection
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
            pg_meta_r <= 1'b0;
            pg_sync_r <= 1'b0;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
            pg_meta_r <= start_pg;
            pg_sync_r <= pg_meta_r;
        end
    end

    // Debounce: one start event per press, re-armed only after the button is released
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            db_cnt_r    <= '0;
            db_armed_r  <= 1'b1;
            start_evt_r <= 1'b0;
        end else begin
            start_evt_r <= 1'b0;
            if (!pg_sync_r) begin
                db_cnt_r   <= '0;
                db_armed_r <= 1'b1;
            end else if (db_armed_r) begin
                if (db_cnt_r == DB_LAST) begin
                    start_evt_r <= 1'b1;
                    db_armed_r  <= 1'b0;
                    db_cnt_r    <= '0;
                end else begin
                    db_cnt_r <= db_cnt_r + 1'b1;
                end
            end
        end
    end

    // Receiver sample strobe and frame outcome on the stop-bit sample
    always_comb begin
        rx_tick_s = rx_busy_r && (rx_cnt_r == '0);
        if (rx_tick_s && (rx_bit_r == 4'd9)) begin
            rx_good_s = rx_sync_r;
            rx_bad_s  = !rx_sync_r;
        end else begin
            rx_good_s = 1'b0;
            rx_bad_s  = 1'b0;
        end
    end

    // UART receiver: start re-checked at half a bit, then 8 data bits LSB first and stop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_busy_r  <= 1'b0;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 4'd0;
            rx_shift_r <= 8'h00;
        end else if (!rx_busy_r) begin
            if (rx_prev_r && !rx_sync_r) begin
                rx_busy_r <= 1'b1;
                rx_cnt_r  <= BAUD_HALF;
                rx_bit_r  <= 4'd0;
            end
        end else if (rx_cnt_r != '0) begin
            rx_cnt_r <= rx_cnt_r - 1'b1;
        end else begin
            rx_cnt_r <= BAUD_LAST;
            case (rx_bit_r)
                4'd0: begin
                    if (rx_sync_r) begin
                        rx_busy_r <= 1'b0;
                    end else begin
                        rx_bit_r <= 4'd1;
                    end
                end
                4'd9: rx_busy_r <= 1'b0;
                default: begin
                    rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
                    rx_bit_r   <= rx_bit_r + 4'd1;
                end
            endcase
        end
    end

    // Word merge, report triggers and the outgoing report frame
    always_comb begin
        word_next_s = word_buf_r;
        word_next_s[8*byte_idx_r +: 8] = rx_shift_r;
        full_s   = upg_wen_r && (upg_adr_r == ADR_LAST);
        tmo_s    = got_byte_r && !rx_good_s && (tmo_cnt_r == TM_LAST);
        if (state_r == ST_LOAD) begin
            to_report_s = full_s || tmo_s;
        end else begin
            to_report_s = 1'b0;
        end
        status_s = ((byte_idx_r != '0) || frame_err_r) ? 8'h45 : 8'h4F;
`ifdef PROG_CKSUM_EN
        tx_frame_s = {1'b1, sum_r, 1'b0, 1'b1, status_s, 1'b0};
`else
        tx_frame_s = {1'b1, status_s, 1'b0};
`endif
    end

    // Loader FSM: load control, word writes, timeout and status transmission
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            byte_idx_r    <= '0;
            word_buf_r    <= '0;
            tmo_cnt_r     <= '0;
            got_byte_r    <= 1'b0;
            tx_frame_r    <= '1;
            tx_left_r     <= '0;
            tx_cnt_r      <= '0;
            tx_r          <= 1'b1;
            upg_wen_r     <= 1'b0;
            upg_adr_r     <= '0;
            upg_dat_r     <= '0;
            upg_done_r    <= 1'b0;
            prog_active_r <= 1'b0;
            frame_err_r   <= 1'b0;
`ifdef PROG_CKSUM_EN
            sum_r         <= 8'h00;
            word_sum_r    <= 8'h00;
`endif
        end else begin
            upg_wen_r <= 1'b0;
            // address advances the cycle after each strobe
            if (upg_wen_r) begin
                upg_adr_r <= upg_adr_r + 1'b1;
            end
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_evt_r) begin
                        state_r       <= ST_LOAD;
                        upg_adr_r     <= '0;
                        byte_idx_r    <= '0;
                        tmo_cnt_r     <= '0;
                        got_byte_r    <= 1'b0;
                        upg_done_r    <= 1'b0;
                        frame_err_r   <= 1'b0;
                        prog_active_r <= 1'b1;
`ifdef PROG_CKSUM_EN
                        sum_r         <= 8'h00;
                        word_sum_r    <= 8'h00;
`endif
                    end
                end
                ST_LOAD: begin
                    if (to_report_s) begin
                        state_r    <= ST_REPORT;
                        tx_r       <= tx_frame_s[0];
                        tx_frame_r <= tx_frame_s[TX_BITS-1:1];
                        tx_left_r  <= TX_LAST;
                        tx_cnt_r   <= BAUD_LAST;
                    end else begin
                        if (rx_bad_s) begin
                            frame_err_r <= 1'b1;
                        end
                        if (rx_good_s) begin
                            word_buf_r <= word_next_s;
                            tmo_cnt_r  <= '0;
                            got_byte_r <= 1'b1;
                            if (byte_idx_r == LAST_IDX) begin
                                upg_dat_r  <= word_next_s;
                                upg_wen_r  <= 1'b1;
                                byte_idx_r <= '0;
`ifdef PROG_CKSUM_EN
                                sum_r      <= sum_r + word_sum_r + rx_shift_r;
                                word_sum_r <= 8'h00;
`endif
                            end else begin
                                byte_idx_r <= byte_idx_r + 1'b1;
`ifdef PROG_CKSUM_EN
                                word_sum_r <= word_sum_r + rx_shift_r;
`endif
                            end
                        end else if (got_byte_r) begin
                            tmo_cnt_r <= tmo_cnt_r + 1'b1;
                        end
                    end
                end
                ST_REPORT: begin
                    if (tx_cnt_r != '0) begin
                        tx_cnt_r <= tx_cnt_r - 1'b1;
                    end else if (tx_left_r == '0) begin
                        state_r       <= ST_DONE;
                        upg_done_r    <= 1'b1;
                        prog_active_r <= 1'b0;
                    end else begin
                        tx_r       <= tx_frame_r[0];
                        tx_frame_r <= {1'b1, tx_frame_r[TX_BITS-2:1]};
                        tx_left_r  <= tx_left_r - 1'b1;
                        tx_cnt_r   <= BAUD_LAST;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign tx           = tx_r;
    assign upg.upg_wen  = upg_wen_r;
    assign upg.upg_adr  = upg_adr_r;
    assign upg.upg_dat  = upg_dat_r;
    assign upg.upg_done = upg_done_r;
    assign prog_active  = prog_active_r;
    assign frame_err    = frame_err_r;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader (small parameters: BAUD 8, 4-word memory).
// Expected writes and report bytes come from a byte-list model of the loader.
module tb_uart_prog_loader;
    localparam int BAUD      = 8;
    localparam int ADDR_W    = 2;
    localparam int DATA_W    = 32;
    localparam int TMO       = 200;
    localparam int CAP_BYTES = 4 * (1 << ADDR_W);
`ifdef PROG_CKSUM_EN
    localparam int TX_N = 2;
`else
    localparam int TX_N = 1;
`endif

    logic clock = 1'b0;
    logic reset, start_pg, rx, tx, prog_active, frame_err;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [ADDR_W-1:0] wr_adr_q[$];
    logic [DATA_W-1:0] wr_dat_q[$];
    logic [7:0]        tx_q[$];
    logic [7:0]        sent_q[$];
    bit                bad_q[$];
    int                long_strobe = 0;
    int                adr_bad = 0;
    int                tx_stop_bad = 0;
    logic              wen_prev = 1'b0;
    logic [ADDR_W-1:0] adr_prev = '0;

    uart_prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) upg_bus ();

    uart_prog_loader #(
        .BAUD_DIV(BAUD), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .DEBOUNCE_CYC(4), .TIMEOUT_CYC(TMO)
    ) dut (
        .clock(clock), .reset(reset), .start_pg(start_pg), .rx(rx), .tx(tx),
        .upg(upg_bus), .prog_active(prog_active), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    // Capture write strobes; flag strobes longer than one cycle and bad address steps
    always @(negedge clock) begin
        if (upg_bus.upg_wen === 1'b1) begin
            wr_adr_q.push_back(upg_bus.upg_adr);
            wr_dat_q.push_back(upg_bus.upg_dat);
        end
        if (wen_prev && (upg_bus.upg_wen === 1'b1)) long_strobe <= long_strobe + 1;
        if (wen_prev && (upg_bus.upg_adr !== ADDR_W'(adr_prev + 1'b1))) adr_bad <= adr_bad + 1;
        wen_prev <= (upg_bus.upg_wen === 1'b1);
        adr_prev <= upg_bus.upg_adr;
    end

    // UART decoder on tx
    initial begin : tx_mon
        forever begin
            @(negedge clock);
            if (tx === 1'b0) begin : frame
                logic [7:0] b;
                repeat (BAUD / 2) @(negedge clock);
                for (int k = 0; k < 8; k++) begin
                    repeat (BAUD) @(negedge clock);
                    b[k] = tx;
                end
                repeat (BAUD) @(negedge clock);
                if (tx !== 1'b1) tx_stop_bad = tx_stop_bad + 1;
                tx_q.push_back(b);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx = f[k];
            repeat (BAUD) @(negedge clock);
        end
        rx = 1'b1;
        repeat (BAUD) @(negedge clock);
    endtask

    task automatic press();
        start_pg = 1'b1;
        repeat (8) @(negedge clock);
        start_pg = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic set_good(input int n);
        bad_q.delete();
        for (int i = 0; i < n; i++) bad_q.push_back(1'b0);
    endtask

    // One complete load: press, send sent_q/bad_q, wait for done, compare against the model
    task automatic do_load(input string tag, input bit early);
        logic [7:0] good[$];
        bit         ferr;
        int         nw, cyc;
        logic [31:0] w;
        logic [7:0] sum, st;
        ferr = 1'b0;
        sum  = 8'h00;
        wr_adr_q.delete();
        wr_dat_q.delete();
        tx_q.delete();
        press();
        chk({tag, "_active"}, prog_active, 1);
        chk({tag, "_done_clr"}, upg_bus.upg_done, 0);
        foreach (sent_q[i]) send_byte(sent_q[i], !bad_q[i]);
        if (early) begin
            repeat (100) @(negedge clock);
            chk({tag, "_early_done"}, upg_bus.upg_done, 1);
        end
        cyc = 0;
        while ((upg_bus.upg_done !== 1'b1) && (cyc < 5000)) begin
            @(negedge clock);
            cyc++;
        end
        chk({tag, "_done_bound"}, cyc < 5000, 1);
        repeat (4) @(negedge clock);
        // model: bytes after memory is full are ignored; bad frames only flag errors
        foreach (sent_q[i]) begin
            if (good.size() == CAP_BYTES) break;
            if (bad_q[i]) ferr = 1'b1;
            else good.push_back(sent_q[i]);
        end
        nw = good.size() / 4;
        st = ((good.size() % 4 != 0) || ferr) ? 8'h45 : 8'h4F;
        for (int j = 0; j < 4 * nw; j++) sum = sum + good[j];
        chk({tag, "_nwr"}, wr_adr_q.size(), nw);
        for (int i = 0; (i < nw) && (i < wr_adr_q.size()); i++) begin
            w = {good[4*i+3], good[4*i+2], good[4*i+1], good[4*i]};
            chk($sformatf("%s_adr%0d", tag, i), wr_adr_q[i], i);
            chk($sformatf("%s_dat%0d", tag, i), wr_dat_q[i], w);
        end
        chk({tag, "_ntx"}, tx_q.size(), TX_N);
        if (tx_q.size() > 0) chk({tag, "_status"}, tx_q[0], st);
`ifdef PROG_CKSUM_EN
        if (tx_q.size() > 1) chk({tag, "_cksum"}, tx_q[1], sum);
`endif
        chk({tag, "_done"}, upg_bus.upg_done, 1);
        chk({tag, "_inactive"}, prog_active, 0);
        chk({tag, "_ferr"}, frame_err, ferr);
        chk({tag, "_adr_end"}, upg_bus.upg_adr, nw % (1 << ADDR_W));
        chk({tag, "_tx_idle"}, tx, 1);
    endtask

    initial begin
        reset    = 1'b0;
        start_pg = 1'b0;
        rx       = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_tx", tx, 1);
        chk("rst_wen", upg_bus.upg_wen, 0);
        chk("rst_adr", upg_bus.upg_adr, 0);
        chk("rst_dat", upg_bus.upg_dat, 0);
        chk("rst_done", upg_bus.upg_done, 0);
        chk("rst_active", prog_active, 0);
        chk("rst_ferr", frame_err, 0);
        reset = 1'b1;
        repeat (5) @(negedge clock);

        // two full words then timeout
        sent_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        set_good(8);
        do_load("two_words", 1'b0);

        // start glitch shorter than the debounce window
        start_pg = 1'b1;
        repeat (3) @(negedge clock);
        start_pg = 1'b0;
        repeat (20) @(negedge clock);
        chk("glitch_active", prog_active, 0);
        chk("glitch_done", upg_bus.upg_done, 1);

        // partial word discarded
        sent_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        set_good(5);
        do_load("partial", 1'b0);

        // framing error mid-word
        sent_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        set_good(5);
        bad_q[1] = 1'b1;
        do_load("frame_err", 1'b0);

        // memory full after 16 bytes, 17th ignored
        sent_q.delete();
        for (int i = 0; i < 17; i++) sent_q.push_back(8'($urandom));
        set_good(17);
        do_load("full", 1'b1);

        // checksum pattern
        sent_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        set_good(4);
        do_load("cksum", 1'b0);

        // randomized loads
        for (int it = 0; it < 4; it++) begin
            int n;
            n = $urandom_range(1, 20);
            sent_q.delete();
            bad_q.delete();
            for (int i = 0; i < n; i++) begin
                sent_q.push_back(8'($urandom));
                bad_q.push_back((i != 0) && ($urandom_range(0, 7) == 0));
            end
            do_load($sformatf("rnd%0d", it), 1'b0);
        end

        // reset in the middle of a word
        wr_adr_q.delete();
        wr_dat_q.delete();
        press();
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        rx = 1'b0;
        repeat (12) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_wen", upg_bus.upg_wen, 0);
        chk("mid_rst_adr", upg_bus.upg_adr, 0);
        chk("mid_rst_dat", upg_bus.upg_dat, 0);
        chk("mid_rst_done", upg_bus.upg_done, 0);
        chk("mid_rst_active", prog_active, 0);
        chk("mid_rst_ferr", frame_err, 0);
        repeat (3) @(negedge clock);
        rx = 1'b1;
        reset = 1'b1;
        repeat (300) @(negedge clock);
        chk("mid_rst_nwr", wr_adr_q.size(), 0);
        chk("mid_rst_idle", prog_active, 0);

        chk("strobe_width", long_strobe, 0);
        chk("adr_step", adr_bad, 0);
        chk("tx_stop", tx_stop_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
